// File: rtl/dma_row_filler_pkg.sv
// Shared widths and state encoding for the DMA row filler.
// Mirrors the platform configuration defaults; MAX_OUT is fixed here.
package dma_row_filler_pkg;

  localparam int CFG_LOCAL_ADDR_BW0 = 8;
  localparam int CFG_GLOBAL_ADDR_BW = 16;
  localparam int CFG_DATA_BW        = 8;
  localparam int CFG_VSIZE          = 4;
  localparam int CFG_MAX_OUT        = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } fill_state_e;

endpackage

// File: rtl/dma_row_filler_if.sv
// Command, global read request/response and SRAM write bundle for the row filler.
// master = the filler itself, slave = its environment.
interface dma_row_filler_if
  import dma_row_filler_pkg::*;
#(
  parameter int HBW   = CFG_LOCAL_ADDR_BW0 - $clog2(CFG_VSIZE),
  parameter int GBW   = CFG_GLOBAL_ADDR_BW,
  parameter int DBW   = CFG_DATA_BW,
  parameter int VSIZE = CFG_VSIZE,
  parameter int NBW   = 8
);

  logic                       rp_en_rdy;
  logic                       rp_en_ack;
  logic [HBW-1:0]             i_lrow;
  logic [GBW-1:0]             i_grow;
  logic [NBW-1:0]             i_nrow;

  logic                       dramra_rdy;
  logic                       dramra_ack;
  logic [GBW-1:0]             o_dramra_addr;

  logic                       dramrd_rdy;
  logic                       dramrd_ack;
  logic [VSIZE-1:0][DBW-1:0]  i_dramrd;

  logic                       dma_write_dval;
  logic [HBW-1:0]             o_dma_whiaddr;
  logic [VSIZE-1:0][DBW-1:0]  o_dma_wdata;

  logic                       o_busy;

  modport master (
    input  rp_en_rdy, i_lrow, i_grow, i_nrow, dramra_ack, dramrd_rdy, i_dramrd,
    output rp_en_ack, dramra_rdy, o_dramra_addr, dramrd_ack,
           dma_write_dval, o_dma_whiaddr, o_dma_wdata, o_busy
  );

  modport slave (
    output rp_en_rdy, i_lrow, i_grow, i_nrow, dramra_ack, dramrd_rdy, i_dramrd,
    input  rp_en_ack, dramra_rdy, o_dramra_addr, dramrd_ack,
           dma_write_dval, o_dma_whiaddr, o_dma_wdata, o_busy
  );

endinterface

// File: rtl/dma_write_reg.sv
// Response-to-SRAM write register: one-cycle delay from response transfer to write strobe.
// Valid-only output, no backpressure; strobe is high exactly one cycle per accepted response.
module dma_write_reg #(
  parameter int HBW   = 6,
  parameter int DBW   = 8,
  parameter int VSIZE = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      wr_en,
  input  logic [HBW-1:0]            wr_addr,
  input  logic [VSIZE-1:0][DBW-1:0] wr_row,
  output logic                      dval,
  output logic [HBW-1:0]            whiaddr,
  output logic [VSIZE-1:0][DBW-1:0] wdata
);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      dval    <= 1'b0;
      whiaddr <= '0;
      wdata   <= '0;
    end else begin
      dval <= wr_en;
      if (wr_en) begin
        whiaddr <= wr_addr;
        wdata   <= wr_row;
      end
    end
  end

endmodule

// File: rtl/dma_row_filler.sv
// Fill-command DMA: issues in-order global row reads (at most MAX_OUT outstanding) and writes rows to SRAM.
// Request in the cycle after command accept, SRAM write one cycle after each response; request side stalls on ack/limit.
module dma_row_filler
  import dma_row_filler_pkg::*;
#(
  parameter int LBW     = CFG_LOCAL_ADDR_BW0,
  parameter int GBW     = CFG_GLOBAL_ADDR_BW,
  parameter int DBW     = CFG_DATA_BW,
  parameter int VSIZE   = CFG_VSIZE,
  parameter int MAX_OUT = CFG_MAX_OUT,
  parameter int NBW     = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  dma_row_filler_if.master bus
);

  localparam int HBW = LBW - $clog2(VSIZE);
  localparam int OBW = $clog2(MAX_OUT + 1);

  fill_state_e     state, state_nxt;
  logic [HBW-1:0]  lrow;
  logic [GBW-1:0]  greq;
  logic [NBW-1:0]  req_left;
  logic [NBW-1:0]  rsp_left;
  logic [OBW-1:0]  out_cnt;

  logic            cmd_ack;
  logic            req_rdy;
  logic            rsp_ack;
  logic            req_fire;
  logic            dval;

  always_comb begin
    state_nxt = state;
    cmd_ack   = 1'b0;
    req_rdy   = 1'b0;
    rsp_ack   = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ack = bus.rp_en_rdy;
        if (bus.rp_en_rdy && (bus.i_nrow != '0)) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        req_rdy = (req_left != '0) && (out_cnt != OBW'(MAX_OUT));
        rsp_ack = bus.dramrd_rdy && (rsp_left != '0);
        if (req_rdy && bus.dramra_ack && (req_left == NBW'(1))) state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        rsp_ack = bus.dramrd_rdy && (rsp_left != '0);
        if (rsp_ack && (rsp_left == NBW'(1))) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign req_fire = req_rdy && bus.dramra_ack;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state    <= ST_IDLE;
      lrow     <= '0;
      greq     <= '0;
      req_left <= '0;
      rsp_left <= '0;
      out_cnt  <= '0;
    end else begin
      state <= state_nxt;
      // Command accept only happens in IDLE, where neither request nor response can fire.
      if (cmd_ack) begin
        lrow     <= bus.i_lrow;
        greq     <= bus.i_grow;
        req_left <= bus.i_nrow;
        rsp_left <= bus.i_nrow;
      end else begin
        if (req_fire) begin
          greq     <= greq + GBW'(1);
          req_left <= req_left - NBW'(1);
        end
        if (rsp_ack) begin
          lrow     <= lrow + HBW'(1);
          rsp_left <= rsp_left - NBW'(1);
        end
      end
      case ({req_fire, rsp_ack})
        2'b10:   out_cnt <= out_cnt + OBW'(1);
        2'b01:   out_cnt <= out_cnt - OBW'(1);
        default: out_cnt <= out_cnt;
      endcase
    end
  end

  dma_write_reg #(
    .HBW   (HBW),
    .DBW   (DBW),
    .VSIZE (VSIZE)
  ) u_write_reg (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .wr_en   (rsp_ack),
    .wr_addr (lrow),
    .wr_row  (bus.i_dramrd),
    .dval    (dval),
    .whiaddr (bus.o_dma_whiaddr),
    .wdata   (bus.o_dma_wdata)
  );

  assign bus.rp_en_ack      = cmd_ack;
  assign bus.dramra_rdy     = req_rdy;
  assign bus.o_dramra_addr  = greq;
  assign bus.dramrd_ack     = rsp_ack;
  assign bus.dma_write_dval = dval;
  assign bus.o_busy         = (state != ST_IDLE) || dval;

endmodule

// File: tb/tb_dma_row_filler.sv
// Bench for dma_row_filler: directed scenarios plus random fills against a row-level model
// of expected request addresses and SRAM writes, with a latency/stall memory responder.
module tb_dma_row_filler;
  import dma_row_filler_pkg::*;

  localparam int LBW = CFG_LOCAL_ADDR_BW0;
  localparam int GBW = CFG_GLOBAL_ADDR_BW;
  localparam int DBW = CFG_DATA_BW;
  localparam int VS  = CFG_VSIZE;
  localparam int MO  = CFG_MAX_OUT;
  localparam int NBW = 8;
  localparam int HBW = LBW - $clog2(VS);

  typedef logic [VS-1:0][DBW-1:0] row_t;

  logic i_clk = 1'b0;
  logic i_rst = 1'b0;
  always #5 i_clk = ~i_clk;

  int cyc = 0;
  int tests_run = 0;
  int tests_failed = 0;
  int lat = 1;
  int stall_pct = 0;
  int unsigned salt = 0;

  logic [GBW-1:0] req_addr_q[$];
  int             req_cyc_q[$];
  int             rsp_cyc_q[$];
  logic [HBW-1:0] wr_addr_q[$];
  row_t           wr_dat_q[$];
  int             wr_cyc_q[$];
  logic [GBW-1:0] pend_addr[$];
  int             pend_due[$];
  int outst = 0, max_out = 0, sim_cnt = 0, proto_err = 0, busy_fall = -1;
  logic prev_busy = 1'b0;

  logic [GBW-1:0] exp_req[$];
  logic [HBW-1:0] exp_wa[$];
  row_t           exp_wd[$];

  dma_row_filler_if #(.HBW(HBW), .GBW(GBW), .DBW(DBW), .VSIZE(VS), .NBW(NBW)) bus ();

  dma_row_filler #(
    .LBW(LBW), .GBW(GBW), .DBW(DBW), .VSIZE(VS), .MAX_OUT(MO), .NBW(NBW)
  ) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  function automatic row_t mem_row(logic [GBW-1:0] a);
    row_t r;
    for (int k = 0; k < VS; k++) r[k] = DBW'(int'(a) * 13 + k * 61 + int'(salt));
    return r;
  endfunction

  function automatic void append_expected(int l, int g, int n);
    for (int i = 0; i < n; i++) begin
      exp_req.push_back(GBW'((g + i) % (1 << GBW)));
      exp_wa.push_back(HBW'((l + i) % (1 << HBW)));
      exp_wd.push_back(mem_row(GBW'((g + i) % (1 << GBW))));
    end
  endfunction

  function automatic void clear_rec();
    req_addr_q.delete(); req_cyc_q.delete(); rsp_cyc_q.delete();
    wr_addr_q.delete(); wr_dat_q.delete(); wr_cyc_q.delete();
    exp_req.delete(); exp_wa.delete(); exp_wd.delete();
    outst = 0; max_out = 0; sim_cnt = 0; proto_err = 0; busy_fall = -1;
  endfunction

  initial forever begin
    @(posedge i_clk);
    cyc++;
  end

  // Monitor: samples at negedge, when every rdy/ack pair is stable until the next edge.
  always @(negedge i_clk) begin
    if (i_rst) begin
      automatic logic rq = bus.dramra_rdy && bus.dramra_ack;
      automatic logic rs = 1'b0;
      if (bus.rp_en_ack && !bus.rp_en_rdy) proto_err++;
      if (rq) begin
        req_addr_q.push_back(bus.o_dramra_addr);
        req_cyc_q.push_back(cyc);
        pend_addr.push_back(bus.o_dramra_addr);
        pend_due.push_back(cyc + lat);
        outst++;
      end
      if (bus.dramrd_ack) begin
        if (!bus.dramrd_rdy || pend_addr.size() == 0) proto_err++;
        else begin
          void'(pend_addr.pop_front());
          void'(pend_due.pop_front());
          rsp_cyc_q.push_back(cyc);
          outst--;
          rs = 1'b1;
        end
      end
      if (rq && rs) sim_cnt++;
      if (outst > max_out) max_out = outst;
      if (bus.dma_write_dval) begin
        wr_addr_q.push_back(bus.o_dma_whiaddr);
        wr_dat_q.push_back(bus.o_dma_wdata);
        wr_cyc_q.push_back(cyc);
      end
      if (prev_busy && !bus.o_busy) busy_fall = cyc;
      prev_busy = bus.o_busy;
    end
  end

  // Memory responder: in-order, fixed latency, random stalls on both channels.
  initial begin
    bus.dramra_ack = 1'b0;
    bus.dramrd_rdy = 1'b0;
    bus.i_dramrd   = '0;
    forever begin
      @(posedge i_clk);
      #1;
      bus.dramra_ack = bus.dramra_rdy && (int'($urandom_range(0, 99)) >= stall_pct);
      if (pend_addr.size() != 0 && pend_due[0] <= cyc && int'($urandom_range(0, 99)) >= stall_pct) begin
        bus.dramrd_rdy = 1'b1;
        bus.i_dramrd   = mem_row(pend_addr[0]);
      end else begin
        bus.dramrd_rdy = 1'b0;
        bus.i_dramrd   = '0;
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs_zero(string nm);
    check({nm, "_rp_en_ack"}, bus.rp_en_ack, 0);
    check({nm, "_dramra_rdy"}, bus.dramra_rdy, 0);
    check({nm, "_dramra_addr"}, bus.o_dramra_addr, 0);
    check({nm, "_dramrd_ack"}, bus.dramrd_ack, 0);
    check({nm, "_dval"}, bus.dma_write_dval, 0);
    check({nm, "_whiaddr"}, bus.o_dma_whiaddr, 0);
    check({nm, "_wdata"}, bus.o_dma_wdata, 0);
    check({nm, "_busy"}, bus.o_busy, 0);
  endtask

  // Present a command, wait for its ack, then confirm the first request slot opens next cycle.
  task automatic issue_cmd(int l, int g, int n, output int ack_c);
    int got = 0;
    ack_c = -1;
    bus.i_lrow    = HBW'(l);
    bus.i_grow    = GBW'(g);
    bus.i_nrow    = NBW'(n);
    bus.rp_en_rdy = 1'b1;
    for (int t = 0; t < 3000 && got == 0; t++) begin
      @(negedge i_clk);
      if (bus.rp_en_ack === 1'b1) begin
        got = 1;
        ack_c = cyc;
      end
    end
    check("cmd_ack_seen", got, 1);
    tick();
    bus.rp_en_rdy = 1'b0;
    @(negedge i_clk);
    check("first_req_rdy", bus.dramra_rdy, (n != 0));
  endtask

  task automatic wait_idle(string nm);
    int done = 0;
    for (int t = 0; t < 5000 && done == 0; t++) begin
      @(negedge i_clk);
      if (!bus.o_busy) done = 1;
    end
    check({nm, "_idle"}, done, 1);
    tick();
  endtask

  task automatic check_fill(string nm);
    check({nm, "_req_cnt"}, req_addr_q.size(), exp_req.size());
    check({nm, "_rsp_cnt"}, rsp_cyc_q.size(), exp_req.size());
    check({nm, "_wr_cnt"}, wr_addr_q.size(), exp_wa.size());
    for (int i = 0; i < exp_req.size() && i < req_addr_q.size(); i++)
      check($sformatf("%s_req_addr[%0d]", nm, i), req_addr_q[i], exp_req[i]);
    for (int i = 0; i < exp_wa.size() && i < wr_addr_q.size(); i++) begin
      check($sformatf("%s_wr_addr[%0d]", nm, i), wr_addr_q[i], exp_wa[i]);
      check($sformatf("%s_wr_data[%0d]", nm, i), wr_dat_q[i], exp_wd[i]);
      if (i < rsp_cyc_q.size())
        check($sformatf("%s_wr_cyc[%0d]", nm, i), wr_cyc_q[i], rsp_cyc_q[i] + 1);
    end
    check({nm, "_protocol"}, proto_err, 0);
    check({nm, "_max_out_le"}, (max_out <= MO), 1);
    if (wr_cyc_q.size() != 0)
      check({nm, "_busy_fall"}, busy_fall, wr_cyc_q[wr_cyc_q.size()-1] + 1);
    clear_rec();
  endtask

  initial begin
    int l, g, n, ack_c, a_last;
    int wrap_exp[4];
    salt = $urandom;
    bus.rp_en_rdy = 1'b0;
    bus.i_lrow    = '0;
    bus.i_grow    = '0;
    bus.i_nrow    = '0;

    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check_outputs_zero("reset");
    tick();
    i_rst = 1'b1;
    tick();

    // Basic fill with the fastest memory
    lat = 1; stall_pct = 0;
    issue_cmd(5, 'h100, 3, ack_c);
    wait_idle("basic");
    append_expected(5, 'h100, 3);
    check_fill("basic");

    // Zero-row command, then a real one the very next cycle
    bus.i_lrow = HBW'(9); bus.i_grow = GBW'('h77); bus.i_nrow = '0;
    bus.rp_en_rdy = 1'b1;
    @(negedge i_clk);
    check("zero_ack", bus.rp_en_ack, 1);
    tick();
    bus.i_lrow = HBW'(20); bus.i_grow = GBW'('h40); bus.i_nrow = NBW'(2);
    @(negedge i_clk);
    check("zero_next_ack", bus.rp_en_ack, 1);
    check("zero_no_req", bus.dramra_rdy, 0);
    check("zero_no_write", bus.dma_write_dval, 0);
    tick();
    bus.rp_en_rdy = 1'b0;
    wait_idle("zero");
    append_expected(20, 'h40, 2);
    check_fill("zero");

    // Outstanding limit under a slow memory
    lat = 20;
    issue_cmd(0, 'h800, 8, ack_c);
    wait_idle("limit");
    check("limit_max_out", max_out, MO);
    n = 0;
    foreach (req_cyc_q[i]) if (rsp_cyc_q.size() != 0 && req_cyc_q[i] < rsp_cyc_q[0]) n++;
    check("limit_reqs_before_rsp", n, MO);
    append_expected(0, 'h800, 8);
    check_fill("limit");

    // Local and global address wrap
    lat = 1;
    issue_cmd((1 << HBW) - 2, 'hFFFE, 4, ack_c);
    wait_idle("wrap");
    wrap_exp = '{(1 << HBW) - 2, (1 << HBW) - 1, 0, 1};
    if (wr_addr_q.size() == 4)
      for (int i = 0; i < 4; i++) check($sformatf("wrap_seq[%0d]", i), wr_addr_q[i], wrap_exp[i]);
    append_expected((1 << HBW) - 2, 'hFFFE, 4);
    check_fill("wrap");

    // Saturated pipeline with same-cycle request/response; second command held while busy
    lat = 4;
    issue_cmd(40, 'h500, 12, ack_c);
    issue_cmd(7, 'h600, 3, ack_c);
    a_last = (rsp_cyc_q.size() >= 12) ? rsp_cyc_q[11] : -100;
    check("busy_cmd_ack_cyc", ack_c, a_last + 1);
    wait_idle("sim");
    check("sim_max_out", max_out, MO);
    check("sim_same_cycle", (sim_cnt > 0), 1);
    append_expected(40, 'h500, 12);
    append_expected(7, 'h600, 3);
    check_fill("sim");

    // Reset in the middle of a command
    lat = 2;
    issue_cmd(10, 'h200, 6, ack_c);
    n = 0;
    for (int t = 0; t < 200 && n == 0; t++) begin
      @(negedge i_clk);
      if (wr_addr_q.size() >= 2) n = 1;
    end
    check("rst_two_writes", n, 1);
    tick();
    i_rst = 1'b0;
    #1;
    check_outputs_zero("midrst");
    pend_addr.delete();
    pend_due.delete();
    clear_rec();
    repeat (2) tick();
    i_rst = 1'b1;
    lat = 1;
    issue_cmd(30, 'h300, 2, ack_c);
    wait_idle("postrst");
    append_expected(30, 'h300, 2);
    check_fill("postrst");

    // Random fills with random latency and stalls
    for (int it = 0; it < 6; it++) begin
      l = int'($urandom_range(0, (1 << HBW) - 1));
      g = int'($urandom_range(0, (1 << GBW) - 1));
      n = int'($urandom_range(1, 24));
      lat = int'($urandom_range(1, 6));
      stall_pct = int'($urandom_range(0, 40));
      issue_cmd(l, g, n, ack_c);
      wait_idle($sformatf("rnd%0d", it));
      append_expected(l, g, n);
      check_fill($sformatf("rnd%0d", it));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
